// File: rtl/colour_pwm_driver.sv
// Sink for the 3-bit colour interface: PWM-dimmed RGB drive plus a checker
// that tracks the 1->2->..->6->1 sequence, counts legal steps and flags errors.
module colour_pwm_driver #(
    parameter int PWM_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       colour,
    input  logic             enable,
    input  logic [PWM_W-1:0] duty,
    input  logic             clr_err,
    output logic             led_r,
    output logic             led_g,
    output logic             led_b,
    output logic             changed,
    output logic [CNT_W-1:0] change_count,
    output logic             err
);

    typedef enum logic {
        IDLE,
        TRACK
    } state_t;

    localparam logic [PWM_W-1:0] PWM_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [2:0]       colour_q;
    logic [2:0]       prev_q, prev_d;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic [2:0]       led_q, led_d;
    logic             changed_q, changed_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             err_set;
    logic             valid;

    function automatic logic [2:0] next_code(input logic [2:0] code);
        return (code == 3'd6) ? 3'd1 : code + 3'd1;
    endfunction

    assign valid = (colour_q != 3'b000) && (colour_q != 3'b111);

    // Duty is only sampled at the last count so a period is never cut short or stretched.
    always_comb begin
        pwm_cnt_d = enable ? pwm_cnt_q + 1'b1 : '0;
        duty_d    = (enable && pwm_cnt_q == PWM_MAX) ? duty : duty_q;
        led_d     = {3{enable & valid & (pwm_cnt_q < duty_q)}} & colour_q;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        prev_d    = prev_q;
        changed_d = 1'b0;
        count_d   = count_q;
        err_set   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d = TRACK;
                    prev_d  = colour_q;
                end else begin
                    err_set = 1'b1;
                end
            end
            TRACK: begin
                if (!valid) begin
                    changed_d = 1'b1;
                    err_set   = 1'b1;
                    state_d   = IDLE;
                end else if (colour_q == prev_q) begin
                    changed_d = 1'b0;
                end else if (colour_q == next_code(prev_q)) begin
                    changed_d = 1'b1;
                    prev_d    = colour_q;
                    if (count_q != CNT_MAX) count_d = count_q + 1'b1;
                end else begin
                    changed_d = 1'b1;
                    err_set   = 1'b1;
                    prev_d    = colour_q;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = err_set ? 1'b1 : (clr_err ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            colour_q  <= '0;
            prev_q    <= '0;
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            led_q     <= '0;
            changed_q <= 1'b0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            colour_q  <= colour;
            prev_q    <= prev_d;
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            led_q     <= led_d;
            changed_q <= changed_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    assign led_r        = led_q[2];
    assign led_g        = led_q[1];
    assign led_b        = led_q[0];
    assign changed      = changed_q;
    assign change_count = count_q;
    assign err          = err_q;

endmodule

// File: tb/tb_colour_pwm_driver.sv
// Directed bench for colour_pwm_driver: a scoreboard of expected change pulses
// per instance, plus direct checks of reset, PWM width and LED gating.
module tb_colour_pwm_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] colour_a, colour_b;
    logic       enable_a, enable_b;
    logic [3:0] duty_a, duty_b;
    logic       clr_err_a, clr_err_b;
    logic       led_r_a, led_g_a, led_b_a, changed_a, err_a;
    logic       led_r_b, led_g_b, led_b_b, changed_b, err_b;
    logic [7:0] count_a;
    logic [1:0] count_b;

    colour_pwm_driver #(.PWM_W(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .colour(colour_a), .enable(enable_a), .duty(duty_a),
        .clr_err(clr_err_a), .led_r(led_r_a), .led_g(led_g_a), .led_b(led_b_a),
        .changed(changed_a), .change_count(count_a), .err(err_a)
    );

    colour_pwm_driver #(.PWM_W(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .colour(colour_b), .enable(enable_b), .duty(duty_b),
        .clr_err(clr_err_b), .led_r(led_r_b), .led_g(led_g_b), .led_b(led_b_b),
        .changed(changed_b), .change_count(count_b), .err(err_b)
    );

    typedef struct {
        int count;
        int err;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_a(input logic [2:0] c, input int hold, input bit push, input int cnt, input int e);
        colour_a = c;
        if (push) q_a.push_back('{count: cnt, err: e});
        tick(hold);
    endtask

    task automatic step_b(input logic [2:0] c, input int hold, input bit push, input int cnt, input int e);
        colour_b = c;
        if (push) q_b.push_back('{count: cnt, err: e});
        tick(hold);
    endtask

    // Monitor: every change pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && changed_a) begin
            check("a_pulse_expected", int'(q_a.size() > 0), 1);
            if (q_a.size() > 0) begin
                ea = q_a.pop_front();
                check("a_pulse_count", int'(count_a), ea.count);
                check("a_pulse_err", int'(err_a), ea.err);
            end
        end
        if (!rst && changed_b) begin
            check("b_pulse_expected", int'(q_b.size() > 0), 1);
            if (q_b.size() > 0) begin
                eb = q_b.pop_front();
                check("b_pulse_count", int'(count_b), eb.count);
                check("b_pulse_err", int'(err_b), eb.err);
            end
        end
    end

    initial begin
        int k, hi_r, hi_g, hi_b;
        rst = 1'b1;
        colour_a = '0; enable_a = 1'b0; duty_a = '0; clr_err_a = 1'b0;
        colour_b = '0; enable_b = 1'b0; duty_b = '0; clr_err_b = 1'b0;

        // Reset state
        tick(3);
        @(negedge clk);
        check("rst_led_r", led_r_a, 0);
        check("rst_led_g", led_g_a, 0);
        check("rst_led_b", led_b_a, 0);
        check("rst_changed", changed_a, 0);
        check("rst_count", int'(count_a), 0);
        check("rst_err", err_a, 0);
        check("rst_b_count", int'(count_b), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(2);
        check("idle_invalid_err", err_a, 1);

        // PWM: colour 101, duty 4, then duty 12 mid-period
        colour_a = 3'b101; duty_a = 4'd4; enable_a = 1'b1;
        k = 0;
        while (led_r_a !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("pwm_first_rise", led_r_a, 1);
        hi_r = 0; hi_g = 0; hi_b = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            hi_r += int'(led_r_a); hi_g += int'(led_g_a); hi_b += int'(led_b_a);
            if (i == 6) duty_a = 4'd12;
        end
        check("pwm_duty4_r", hi_r, 4);
        check("pwm_duty4_b", hi_b, 4);
        check("pwm_duty4_g", hi_g, 0);
        hi_r = 0; hi_b = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            hi_r += int'(led_r_a); hi_b += int'(led_b_a);
        end
        check("pwm_duty12_r", hi_r, 12);
        check("pwm_duty12_b", hi_b, 12);

        // Asynchronous reset while an LED is lit
        k = 0;
        while (led_r_a !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("pre_reset_led_on", led_r_a, 1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_led_r", led_r_a, 0);
        check("async_rst_led_b", led_b_a, 0);
        check("async_rst_err", err_a, 0);
        colour_a = 3'b001;
        @(posedge clk); #1;
        rst = 1'b0;
        tick(3);
        clr_err_a = 1'b1;
        tick(1);
        clr_err_a = 1'b0;
        tick(1);
        check("clr_err", err_a, 0);

        // Legal sequence 1->2->3->4->5->6->1
        step_a(3'd2, 3, 1, 1, 0);
        step_a(3'd3, 3, 1, 2, 0);
        step_a(3'd4, 3, 1, 3, 0);
        step_a(3'd5, 3, 1, 4, 0);
        step_a(3'd6, 3, 1, 5, 0);
        step_a(3'd1, 3, 1, 6, 0);
        check("seq_count", int'(count_a), 6);
        check("seq_err", err_a, 0);
        check("seq_all_pulses", int'(q_a.size()), 0);

        // Illegal jump 010 -> 101, then legal 110
        step_a(3'd2, 3, 1, 7, 0);
        step_a(3'd5, 3, 1, 7, 1);
        step_a(3'd6, 3, 1, 8, 1);
        check("jump_count", int'(count_a), 8);

        // Invalid code 111 while tracking
        clr_err_a = 1'b1;
        tick(1);
        clr_err_a = 1'b0;
        tick(1);
        check("clr_before_invalid", err_a, 0);
        step_a(3'd7, 2, 1, 8, 1);
        hi_r = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            hi_r += int'(led_r_a) + int'(led_g_a) + int'(led_b_a);
        end
        check("invalid_leds_off", hi_r, 0);
        check("invalid_err", err_a, 1);
        step_a(3'd3, 3, 0, 0, 0);
        clr_err_a = 1'b1;
        tick(1);
        clr_err_a = 1'b0;
        tick(1);
        check("resync_err_cleared", err_a, 0);
        colour_a = 3'd6;
        q_a.push_back('{count: 8, err: 1});
        tick(1);
        clr_err_a = 1'b1;
        tick(1);
        clr_err_a = 1'b0;
        tick(2);
        check("set_beats_clear", err_a, 1);
        check("resync_count", int'(count_a), 8);

        // Asynchronous reset with a non-zero count and err set
        #2 rst = 1'b1;
        #1;
        check("rst2_count", int'(count_a), 0);
        check("rst2_err", err_a, 0);
        check("rst2_changed", changed_a, 0);
        colour_a = 3'b000;
        enable_a = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Saturation and enable gating on the 2-bit counter instance
        colour_b = 3'd1; enable_b = 1'b1; duty_b = 4'd8;
        tick(3);
        clr_err_b = 1'b1;
        tick(1);
        clr_err_b = 1'b0;
        tick(1);
        step_b(3'd2, 3, 1, 1, 0);
        step_b(3'd3, 3, 1, 2, 0);
        step_b(3'd4, 3, 1, 3, 0);
        step_b(3'd5, 3, 1, 3, 0);
        step_b(3'd6, 3, 1, 3, 0);
        check("sat_count", int'(count_b), 3);
        tick(20);
        hi_r = 0; hi_g = 0; hi_b = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            hi_r += int'(led_r_b); hi_g += int'(led_g_b); hi_b += int'(led_b_b);
        end
        check("b_pwm_r", hi_r, 8);
        check("b_pwm_g", hi_g, 8);
        check("b_pwm_b", hi_b, 0);
        k = 0;
        while (led_r_b !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("b_led_on_before_disable", led_r_b, 1);
        enable_b = 1'b0;
        colour_b = 3'd1;
        q_b.push_back('{count: 3, err: 0});
        tick(1);
        check("disable_led_r", led_r_b, 0);
        check("disable_led_g", led_g_b, 0);
        hi_r = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            hi_r += int'(led_r_b) + int'(led_g_b) + int'(led_b_b);
        end
        check("disable_leds_stay_off", hi_r, 0);
        check("disable_count_saturated", int'(count_b), 3);

        tick(2);
        check("a_no_missing_pulses", int'(q_a.size()), 0);
        check("b_no_missing_pulses", int'(q_b.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
